song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
- Upstream stage of the piano tone generator. It produces the 10-bit key vector that the tone generator consumes: [9:7] one-hot octave (001 low, 010 medium, 100 high) and [6:0] one-hot note (bit0 Do … bit6 Si).
- In idle it registers and passes through the manual switch vector.
- On start it plays a fixed melody from an internal ROM, with per-note duration and a silent articulation gap between notes.

Parameters:
- BEAT_CYCLES, 25000000, clock cycles per beat (0.25 s at 100 MHz).
- GAP_CYCLES, 1000000, silent cycles at the end of each entry; must be less than BEAT_CYCLES.
- SONG_LEN, 16, ROM depth; note_idx width is 4.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins playback from entry 0.
- stop  in  1  single-cycle pulse; aborts playback.
- loop_en  in  1  1 = restart at entry 0 on reaching the end marker.
- manual_ios  in  10  raw switch vector, passed through in IDLE.
- ios  out  10  key vector to the tone generator; registered.
- playing  out  1  high while in NOTE or GAP.
- note_idx  out  4  index of the ROM entry currently playing.
- done  out  1  one-cycle pulse when a non-looping song completes.

Behaviour:
- ROM entry format, 8 bits:
  - [7:6] octave: 0 rest, 1 low, 2 medium, 3 high.
  - [5:3] note index 0..6.
  - [2:0] duration in beats minus 1.
  - Octave 0 with note 7 is the END marker. Octave 0 with any other note is a rest. Nonzero octave with note 7 is treated as a rest.
- Default ROM contents:
  - Entries 0..6: medium Do..Si, duration 0.
  - Entry 7: high Do, duration 1.
  - Entry 8: rest, duration 0.
  - Entries 9..15: END.
- Reset (asynchronous, active-low) sets immediately, without a clock edge: state IDLE, ios=0, playing=0, note_idx=0, done=0, all counters 0.
- States: IDLE, NOTE, GAP.
- IDLE:
  - ios <= manual_ios every cycle (one-cycle latency).
  - When start is sampled high and stop is low: note_idx <= 0, state <= NOTE, and ios <= decode(rom[0]) on the same edge.
  - If rom[0] is END, stay in IDLE and pulse done.
- NOTE:
  - ios holds decode(entry). A rest entry decodes to 0.
  - Lasts (dur+1)*BEAT_CYCLES - GAP_CYCLES cycles, then goes to GAP with ios <= 0.
- GAP:
  - ios = 0 for GAP_CYCLES cycles.
  - On the final GAP cycle the next entry is evaluated (see end-of-entry rule).
- End-of-entry rule (next = note_idx+1; wraps to 0 after SONG_LEN-1, and the wrap is treated as END):
  - Next entry is not END: note_idx <= next, state <= NOTE, ios <= decode(next) on the same edge. There are no extra cycles between GAP and NOTE.
  - Next entry is END and loop_en=1: note_idx <= 0, go to NOTE with entry 0. done is not pulsed.
  - Next entry is END and loop_en=0: done <= 1 for exactly one cycle, state <= IDLE, playing <= 0, ios <= manual_ios.
- Decode mapping:
  - ios[9:7] = 001/010/100 for octave 1/2/3, 000 for rest.
  - ios[6:0] = 1 << note, 0 for rest.
- Stop:
  - In NOTE or GAP: on the next edge state <= IDLE, playing <= 0, ios <= manual_ios, note_idx holds its value, done stays 0.
  - stop has priority over start in the same cycle.
  - stop in IDLE has no effect.
- start while playing is ignored.
- loop_en is sampled only at the end-of-entry decision.
- playing is registered alongside state: 1 in NOTE/GAP, 0 in IDLE.
- Counter width is sized for 8*BEAT_CYCLES. The counter is reloaded on every state entry, with no carry between states.

Test Plan:
All scenarios use BEAT_CYCLES=10 and GAP_CYCLES=2.
1. Reset and pass-through:
   - Hold reset low, manual_ios=10'b010_0000100 -> ios=0, playing=0, done=0.
   - Release reset -> ios=10'b010_0000100 after one edge.
   - Change manual_ios to 10'b100_0000001 -> ios follows one cycle later.
2. Start and timing:
   - Pulse start -> next edge ios=10'b010_0000001, note_idx=0, playing=1.
   - ios holds for 8 cycles, is 0 for 2 cycles, then ios=10'b010_0000010 with note_idx=1.
   - The pattern continues through 10'b010_1000000.
3. Long note, rest and end:
   - Entry 7: ios=10'b100_0000001 for 18 cycles, then 0 for 2 cycles.
   - Entry 8: ios=0 for 10 cycles.
   - done high for exactly 1 cycle exactly 100 cycles after the start edge, then playing=0 and ios=manual_ios.
4. Loop:
   - loop_en=1 through the song -> after entry 8, note_idx=0 and ios=10'b010_0000001, done never asserted.
   - Deassert loop_en in the second pass -> song ends with a single done pulse.
5. Stop and conflicts:
   - Pulse stop at cycle 35 (entry 3 NOTE) -> next edge playing=0, ios=manual_ios, note_idx=3, no done.
   - start and stop in the same cycle from IDLE -> stays IDLE.
   - start pulse mid-song -> no restart, note_idx unchanged.
6. Asynchronous reset mid-play:
   - Assert reset between clock edges during NOTE -> ios=0 and playing=0 immediately, without a clock edge.
   - Release reset -> IDLE pass-through; a fresh start plays from entry 0.

Source files
------------

// File: rtl/song_sequencer_if.sv
// -----------------------------------------------------------------------------
// song_sequencer_if
// Bundles the control, pass-through and key-vector signals of the song
// sequencer so that the sequencer and its driver share one connection.
//
// Signals:
//   start       1  single-cycle pulse, begins playback from entry 0
//   stop        1  single-cycle pulse, aborts playback
//   loop_en     1  restart at entry 0 when the end marker is reached
//   manual_ios  10 raw switch vector, passed through while idle
//   ios         10 key vector to the tone generator ([9:7] octave, [6:0] note)
//   playing     1  high while a note or an articulation gap is in progress
//   note_idx    4  ROM entry currently playing
//   done        1  one-cycle pulse when a non-looping song completes
//
// Modports:
//   master  drives the controls and reads the key vector (controller/bench)
//   slave   the sequencer itself
// -----------------------------------------------------------------------------
interface song_sequencer_if;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic [9:0] manual_ios;
    logic [9:0] ios;
    logic       playing;
    logic [3:0] note_idx;
    logic       done;

    modport master (
        output start,
        output stop,
        output loop_en,
        output manual_ios,
        input  ios,
        input  playing,
        input  note_idx,
        input  done
    );

    modport slave (
        input  start,
        input  stop,
        input  loop_en,
        input  manual_ios,
        output ios,
        output playing,
        output note_idx,
        output done
    );
endinterface

// File: rtl/song_sequencer.sv
// -----------------------------------------------------------------------------
// song_sequencer
// Upstream stage of the piano tone generator. While idle it registers the
// manual switch vector onto ios. On start it plays a fixed 16-entry melody
// ROM: every entry sounds for (dur+1) beats minus a short silent gap, so that
// repeated notes are articulated. All outputs are registered.
//
// Parameters:
//   BEAT_CYCLES  clock cycles per beat
//   GAP_CYCLES   silent cycles at the end of each entry (1 .. BEAT_CYCLES-1)
//   SONG_LEN     ROM depth (note_idx is 4 bits wide)
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    song_sequencer_if.slave (start, stop, loop_en, manual_ios in;
//          ios, playing, note_idx, done out)
// -----------------------------------------------------------------------------
module song_sequencer #(
    parameter int BEAT_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 1000000,
    parameter int SONG_LEN    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    song_sequencer_if.slave        bus
);

    // Longest entry is 8 beats; the counter only ever holds a remaining count.
    localparam int CNT_W = $clog2(8 * BEAT_CYCLES + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t GAP_LOAD = cnt_t'(GAP_CYCLES - 1);
    localparam logic [3:0] LAST_IDX = 4'(SONG_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_NOTE = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    // ROM entry: [7:6] octave (0 rest), [5:3] note, [2:0] beats-1.
    function automatic logic [7:0] rom_entry(input logic [3:0] idx);
        logic [7:0] entry;
        case (idx)
            4'd0:    entry = 8'b10_000_000;
            4'd1:    entry = 8'b10_001_000;
            4'd2:    entry = 8'b10_010_000;
            4'd3:    entry = 8'b10_011_000;
            4'd4:    entry = 8'b10_100_000;
            4'd5:    entry = 8'b10_101_000;
            4'd6:    entry = 8'b10_110_000;
            4'd7:    entry = 8'b11_000_001;
            4'd8:    entry = 8'b00_000_000;
            default: entry = 8'b00_111_000;
        endcase
        return entry;
    endfunction

    // Octave 0 combined with note 7 terminates the song.
    function automatic logic is_end(input logic [7:0] entry);
        return (entry[7:6] == 2'b00) && (entry[5:3] == 3'b111);
    endfunction

    // Rests (octave 0, or note 7 in any octave) produce a silent key vector.
    function automatic logic [9:0] decode(input logic [7:0] entry);
        logic [2:0] oct;
        logic [6:0] key;
        oct = 3'b000;
        key = 7'b0000000;
        if ((entry[7:6] != 2'b00) && (entry[5:3] != 3'b111)) begin
            case (entry[7:6])
                2'b01:   oct = 3'b001;
                2'b10:   oct = 3'b010;
                2'b11:   oct = 3'b100;
                default: oct = 3'b000;
            endcase
            key = 7'b0000001 << entry[5:3];
        end else begin
            oct = 3'b000;
            key = 7'b0000000;
        end
        return {oct, key};
    endfunction

    // Counter load for the sounding part of an entry; the counter expires
    // when it reads zero, hence the trailing -1.
    function automatic cnt_t note_load(input logic [7:0] entry);
        logic [31:0] beats;
        beats = {29'd0, entry[2:0]} + 32'd1;
        return cnt_t'(beats * 32'(BEAT_CYCLES) - 32'(GAP_CYCLES) - 32'd1);
    endfunction

    state_t     state_r,    state_s;
    cnt_t       cnt_r,      cnt_s;
    logic [9:0] ios_r,      ios_s;
    logic       playing_r,  playing_s;
    logic [3:0] note_idx_r, note_idx_s;
    logic       done_r,     done_s;

    logic [3:0] next_idx_s;
    logic [7:0] next_entry_s;
    logic [7:0] first_entry_s;
    logic       wrap_s;

    // Next-state and next-output logic for the IDLE/NOTE/GAP sequencer.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        ios_s         = ios_r;
        playing_s     = playing_r;
        note_idx_s    = note_idx_r;
        done_s        = 1'b0;
        next_idx_s    = note_idx_r + 4'd1;
        next_entry_s  = rom_entry(next_idx_s);
        first_entry_s = rom_entry(4'd0);
        wrap_s        = (note_idx_r == LAST_IDX);

        case (state_r)
            ST_IDLE: begin
                ios_s     = bus.manual_ios;
                playing_s = 1'b0;
                cnt_s     = '0;
                if (bus.start && !bus.stop) begin
                    if (is_end(first_entry_s)) begin
                        done_s = 1'b1;
                    end else begin
                        state_s    = ST_NOTE;
                        note_idx_s = 4'd0;
                        ios_s      = decode(first_entry_s);
                        playing_s  = 1'b1;
                        cnt_s      = note_load(first_entry_s);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_NOTE: begin
                if (bus.stop) begin
                    state_s   = ST_IDLE;
                    playing_s = 1'b0;
                    ios_s     = bus.manual_ios;
                    cnt_s     = '0;
                end else if (cnt_r == '0) begin
                    state_s = ST_GAP;
                    ios_s   = 10'd0;
                    cnt_s   = GAP_LOAD;
                end else begin
                    cnt_s = cnt_r - cnt_t'(1);
                end
            end

            ST_GAP: begin
                if (bus.stop) begin
                    state_s   = ST_IDLE;
                    playing_s = 1'b0;
                    ios_s     = bus.manual_ios;
                    cnt_s     = '0;
                end else if (cnt_r == '0) begin
                    // Last gap cycle: step straight into the following entry.
                    if (!wrap_s && !is_end(next_entry_s)) begin
                        state_s    = ST_NOTE;
                        note_idx_s = next_idx_s;
                        ios_s      = decode(next_entry_s);
                        cnt_s      = note_load(next_entry_s);
                    end else if (bus.loop_en && !is_end(first_entry_s)) begin
                        state_s    = ST_NOTE;
                        note_idx_s = 4'd0;
                        ios_s      = decode(first_entry_s);
                        cnt_s      = note_load(first_entry_s);
                    end else begin
                        state_s   = ST_IDLE;
                        playing_s = 1'b0;
                        ios_s     = bus.manual_ios;
                        done_s    = 1'b1;
                        cnt_s     = '0;
                    end
                end else begin
                    cnt_s = cnt_r - cnt_t'(1);
                end
            end

            default: begin
                state_s   = ST_IDLE;
                playing_s = 1'b0;
                ios_s     = 10'd0;
                cnt_s     = '0;
            end
        endcase
    end

    // State, counter and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            ios_r      <= 10'd0;
            playing_r  <= 1'b0;
            note_idx_r <= 4'd0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            ios_r      <= ios_s;
            playing_r  <= playing_s;
            note_idx_r <= note_idx_s;
            done_r     <= done_s;
        end
    end

    assign bus.ios      = ios_r;
    assign bus.playing  = playing_r;
    assign bus.note_idx = note_idx_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_song_sequencer.sv
// -----------------------------------------------------------------------------
// tb_song_sequencer
// Self-checking bench for song_sequencer with BEAT_CYCLES=10, GAP_CYCLES=2.
// A directed vector table covers reset, pass-through and the first entries;
// hand-written sequences cover song end, looping, stop and conflicts, and an
// asynchronous reset; a random phase compares against a reference model that
// tracks the song as (entry, elapsed cycles) over a table of expected keys.
// -----------------------------------------------------------------------------
module tb_song_sequencer;
    localparam int BEAT   = 10;
    localparam int GAP    = 2;
    localparam int SONG_N = 9;

    localparam logic [9:0] MAN_A = 10'b010_0000100;
    localparam logic [9:0] MAN_B = 10'b100_0000001;

    logic clk = 1'b0;
    logic reset;

    song_sequencer_if bus();

    song_sequencer #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAP),
        .SONG_LEN    (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected melody: key vector and length in beats of each playable entry.
    logic [9:0] song_ios   [SONG_N];
    int         song_beats [SONG_N];

    // Reference model state.
    bit         m_play;
    int         m_idx;
    int         m_t;
    logic [9:0] m_ios;
    bit         m_done;

    task automatic model_reset();
        m_play = 1'b0;
        m_idx  = 0;
        m_t    = 0;
        m_ios  = 10'd0;
        m_done = 1'b0;
    endtask

    task automatic model_edge(input bit st, input bit sp, input bit lp, input logic [9:0] man);
        m_done = 1'b0;
        if (!m_play) begin
            if (st && !sp) begin
                m_play = 1'b1;
                m_idx  = 0;
                m_t    = 0;
            end
        end else if (sp) begin
            m_play = 1'b0;
        end else begin
            m_t++;
            if (m_t == song_beats[m_idx] * BEAT) begin
                if (m_idx + 1 < SONG_N) begin
                    m_idx++;
                    m_t = 0;
                end else if (lp) begin
                    m_idx = 0;
                    m_t   = 0;
                end else begin
                    m_play = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
        if (m_play)
            m_ios = (m_t < song_beats[m_idx] * BEAT - GAP) ? song_ios[m_idx] : 10'd0;
        else
            m_ios = man;
    endtask

    // One clock with model update and full output comparison.
    task automatic cycle();
        @(posedge clk);
        model_edge(bus.start, bus.stop, bus.loop_en, bus.manual_ios);
        #1;
        chk("ios",      32'(bus.ios),      32'(m_ios));
        chk("playing",  32'(bus.playing),  32'(m_play));
        chk("note_idx", 32'(bus.note_idx), 32'(m_idx));
        chk("done",     32'(bus.done),     32'(m_done));
    endtask

    typedef struct packed {
        logic       start;
        logic       stop;
        logic [9:0] man;
        logic [9:0] e_ios;
        logic       e_play;
        logic [3:0] e_idx;
        logic       e_done;
    } vec_t;

    vec_t vecs [13];

    int done_cnt;
    int done_at;

    initial begin
        for (int i = 0; i < 7; i++) begin
            song_ios[i]   = {3'b010, 7'(1 << i)};
            song_beats[i] = 1;
        end
        song_ios[7]   = {3'b100, 7'b0000001};
        song_beats[7] = 2;
        song_ios[8]   = 10'd0;
        song_beats[8] = 1;

        vecs[0] = '{1'b0, 1'b0, MAN_A, MAN_A, 1'b0, 4'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, MAN_B, MAN_B, 1'b0, 4'd0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, MAN_B, 10'b010_0000001, 1'b1, 4'd0, 1'b0};
        for (int i = 3; i <= 9; i++)
            vecs[i] = '{1'b0, 1'b0, MAN_B, 10'b010_0000001, 1'b1, 4'd0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, MAN_B, 10'd0, 1'b1, 4'd0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, MAN_B, 10'd0, 1'b1, 4'd0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, MAN_B, 10'b010_0000010, 1'b1, 4'd1, 1'b0};

        // Reset held low: outputs cleared without any dependence on edges.
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.loop_en    = 1'b0;
        bus.manual_ios = MAN_A;
        #22;
        chk("rst_ios",     32'(bus.ios),      32'd0);
        chk("rst_playing", 32'(bus.playing),  32'd0);
        chk("rst_done",    32'(bus.done),     32'd0);
        chk("rst_idx",     32'(bus.note_idx), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Directed vector table: pass-through, start, first note, gap, second note.
        for (int v = 0; v < 13; v++) begin
            bus.start      = vecs[v].start;
            bus.stop       = vecs[v].stop;
            bus.manual_ios = vecs[v].man;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_ios", v),  32'(bus.ios),      32'(vecs[v].e_ios));
            chk($sformatf("vec%0d_play", v), 32'(bus.playing),  32'(vecs[v].e_play));
            chk($sformatf("vec%0d_idx", v),  32'(bus.note_idx), 32'(vecs[v].e_idx));
            chk($sformatf("vec%0d_done", v), 32'(bus.done),     32'(vecs[v].e_done));
        end
        bus.start = 1'b0;

        // Asynchronous reset between edges while a note is sounding.
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_ios",     32'(bus.ios),      32'd0);
        chk("async_rst_playing", 32'(bus.playing),  32'd0);
        chk("async_rst_idx",     32'(bus.note_idx), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.manual_ios = MAN_A;
        cycle();
        cycle();

        // Full song from entry 0: done exactly 100 cycles after the start edge.
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        chk("restart_idx", 32'(bus.note_idx), 32'd0);
        done_cnt = 0;
        done_at  = -1;
        for (int c = 1; c <= 110; c++) begin
            cycle();
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
        end
        chk("song_done_at",  32'(done_at),  32'd100);
        chk("song_done_cnt", 32'(done_cnt), 32'd1);
        chk("song_end_ios",  32'(bus.ios),  32'(bus.manual_ios));

        // Looping: wraps to entry 0 with no done, then ends once loop_en drops.
        bus.loop_en = 1'b1;
        bus.start   = 1'b1;
        cycle();
        bus.start = 1'b0;
        done_cnt  = 0;
        for (int c = 1; c <= 100; c++) begin
            cycle();
            if (bus.done === 1'b1) done_cnt++;
        end
        chk("loop_idx",     32'(bus.note_idx), 32'd0);
        chk("loop_ios",     32'(bus.ios),      32'(10'b010_0000001));
        chk("loop_playing", 32'(bus.playing),  32'd1);
        chk("loop_no_done", 32'(done_cnt),     32'd0);
        for (int c = 1; c <= 20; c++) cycle();
        bus.loop_en = 1'b0;
        done_cnt = 0;
        done_at  = -1;
        for (int c = 21; c <= 110; c++) begin
            cycle();
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
        end
        chk("loop_end_done_cnt", 32'(done_cnt), 32'd1);
        chk("loop_end_done_at",  32'(done_at),  32'd100);

        // Stop sampled on cycle 35, during entry 3.
        bus.manual_ios = MAN_B;
        bus.start      = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int c = 1; c <= 34; c++) cycle();
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;
        chk("stop_playing", 32'(bus.playing),  32'd0);
        chk("stop_idx",     32'(bus.note_idx), 32'd3);
        chk("stop_ios",     32'(bus.ios),      32'(MAN_B));
        chk("stop_done",    32'(bus.done),     32'd0);

        // start and stop together from idle: stop wins.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        cycle();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("conflict_playing", 32'(bus.playing), 32'd0);
        cycle();

        // start while playing is ignored.
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int c = 1; c <= 15; c++) cycle();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        chk("midsong_start_idx",  32'(bus.note_idx), 32'd1);
        chk("midsong_start_play", 32'(bus.playing),  32'd1);
        for (int c = 1; c <= 5; c++) cycle();
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;

        // Random pulses, loop toggling and switch changes against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.start = ($urandom_range(0, 39) == 0);
            bus.stop  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) bus.loop_en = ~bus.loop_en;
            if ($urandom_range(0, 3) == 0) bus.manual_ios = 10'($urandom);
            cycle();
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
